rv32m_muldiv_unit: RTL and testbench
====================================

# rv32m_muldiv_unit

Iterative RV32M multiply/divide execution unit sitting directly downstream of the register file read ports: it consumes the two source operands (RD1/RD2) plus the destination index, computes over multiple cycles, and emits a result with write-back address and write-enable that drive the register file write port (WD3/A3/WE3). A start/busy/done handshake lets the core stall while the unit is occupied.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  in  32  operand A (from RD1).
- rs2_val  in  32  operand B (from RD2).
- rd_in  in  5  destination register index.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse, result valid.
- result  out  32  to WD3; held until next accepted start.
- wb_addr  out  5  to A3; captured rd_in.
- wb_we  out  1  to WE3; = done and wb_addr != 0.

## Operation
- States: IDLE, CALC, DONE. IDLE+start → CALC (iterative case) or DONE (special/fast case). CALC after 32 iterations → DONE. DONE → IDLE unconditionally.
- On accept: latch op, rd_in, operand magnitudes and sign flags; clear 6-bit iteration counter.
- Signedness: MUL/MULH/DIV/REM both signed; MULHSU A signed, B unsigned; MULHU/DIVU/REMU unsigned.
- Multiply: 32 shift-add iterations on magnitudes into 64-bit accumulator; negate 64-bit product if signs differ. MUL returns bits [31:0]; MULH* return [63:32].
- Divide: 32 restoring iterations on magnitudes; quotient negated if signs differ (signed ops), remainder takes dividend sign.
- Special cases (resolve on accept, no CALC): divide by zero → quotient 0xFFFFFFFF, remainder = rs1_val (all divide ops); signed overflow 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- start while busy: ignored, no state change, operands not latched.
- Reset (any state, mid-operation included): IDLE, counter 0, busy/done/wb_we 0, result 0, wb_addr 0; in-flight operation discarded.

## Timing
- Accept edge E0 (start=1 in IDLE). Iterative: one iteration per edge E1..E32; DONE entered at E32; done/wb_we high for the cycle after E32; IDLE at E33; next start may be accepted at E33.
- Special/fast case: DONE entered at E0; done high for the cycle after E0.
- busy goes high the cycle after E0, low the cycle after DONE exits.
- result/wb_addr registered; stable from done cycle until next accept.
- done never asserts two consecutive cycles.

## Configuration
- MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit signed-extended product, completing with special-case latency (done after E0); divides unchanged.
- Undefined: all multiplies use the 32-iteration path; no hardware multiplier inferred.

## Structure
- Shared package rv32m_pkg: funct3 op constants, state encodings, ITER_COUNT=32, DIV_ZERO_Q=32'hFFFFFFFF, INT_MIN=32'h80000000.
- One sub-module: muldiv_iter_core — single shift-add / restore-subtract step on {acc, operand} per enable; FSM, sign handling and special cases stay in top.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5 → done in cycle after E32, result 0xFFFFFFEB, wb_addr 5, wb_we 1.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; with MULDIV_FAST_MUL_EN, done in cycle after E0.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, done in cycle after E0; REM same → 0.
- DIVU 100 / 0 → 0xFFFFFFFF; REMU 100 / 0 → 100; both done in cycle after E0.
- REM 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFF; DIV same → 0xFFFFFFFD; rd=0 → done 1, wb_we 0.
- Start DIVU accepted, second start at E5 ignored, rst low at E10 → busy/done/result 0 immediately; after release, new MUL 3×4 → 12.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared constants, state encoding and helpers for the RV32M multiply/divide unit.
package rv32m_pkg;

  localparam int ITER_COUNT = 32;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One shift-add (multiply) or restore-subtract (divide) step per enable on {acc, q}.
// After 32 steps: multiply leaves the 64-bit product in {acc, q}; divide leaves remainder in acc, quotient in q.
module muldiv_iter_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] acc_next,
  output logic [31:0] q_next
);

  logic [31:0] acc;
  logic [31:0] q;
  logic [31:0] opnd;
  logic [32:0] sum;
  logic [32:0] shifted;

  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, opnd} : 33'd0);
    shifted = {acc, q[31]};
    if (is_div) begin
      // Trial result is below the divisor, so the low 32 bits of the difference are exact.
      if (shifted >= {1'b0, opnd}) begin
        acc_next = shifted[31:0] - opnd;
        q_next   = {q[30:0], 1'b1};
      end else begin
        acc_next = shifted[31:0];
        q_next   = {q[30:0], 1'b0};
      end
    end else begin
      acc_next = sum[32:1];
      q_next   = {sum[0], q[31:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      q    <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= '0;
      q    <= a;
      opnd <= b;
    end else if (step) begin
      acc  <= acc_next;
      q    <= q_next;
    end
  end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register-file write port.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplier for MUL/MULH/MULHSU/MULHU.
module rv32m_muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_addr,
  output logic            wb_we,
  output logic [1:0]      dbg_state
);

  // Handshake: start is accepted only when the unit is idle (busy low); a start seen
  // while busy is dropped. done pulses for exactly one cycle with result/wb_addr valid,
  // and both stay stable until the next accepted start.

  state_t      state;
  logic [2:0]  op_r;
  logic        neg_res;
  logic        a_neg_r;
  logic [5:0]  count;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic        special;
  logic [31:0] special_res;
  logic [31:0] acc_next, q_next;
  logic [63:0] prod;
  logic [31:0] final_res;
  logic        accept;
  logic        core_load;
  logic        core_step;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_a, fast_b, fast_prod;
`endif

  assign dbg_state = state;
  assign accept    = (state == ST_IDLE) && start;
  assign core_load = accept && !special;
  assign core_step = (state == ST_CALC);

  always_comb begin
    a_signed    = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    b_signed    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg       = a_signed & rs1_val[31];
    b_neg       = b_signed & rs2_val[31];
    mag_a       = neg_if(a_neg, rs1_val);
    mag_b       = neg_if(b_neg, rs2_val);
    special     = 1'b0;
    special_res = '0;
`ifdef MULDIV_FAST_MUL_EN
    fast_a    = {{32{a_neg}}, rs1_val};
    fast_b    = {{32{b_neg}}, rs2_val};
    fast_prod = fast_a * fast_b;
`endif
    if (op[2]) begin
      if (rs2_val == '0) begin
        special     = 1'b1;
        special_res = op[1] ? rs1_val : DIV_ZERO_Q;
      end else if (!op[0] && rs1_val == INT_MIN && rs2_val == 32'hFFFF_FFFF) begin
        special     = 1'b1;
        special_res = op[1] ? 32'd0 : INT_MIN;
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      special     = 1'b1;
      special_res = (op == OP_MUL) ? fast_prod[31:0] : fast_prod[63:32];
    end
`endif
  end

  // Final result is formed from the core's post-step value so it can be registered on the last iteration edge.
  always_comb begin
    prod = {acc_next, q_next};
    if (neg_res) prod = ~prod + 64'd1;
    if (op_r[2]) begin
      final_res = op_r[1] ? neg_if(a_neg_r, acc_next) : neg_if(neg_res, q_next);
    end else begin
      final_res = (op_r == OP_MUL) ? prod[31:0] : prod[63:32];
    end
  end

  muldiv_iter_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .is_div   (op_r[2]),
    .a        (mag_a),
    .b        (mag_b),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      op_r    <= '0;
      neg_res <= 1'b0;
      a_neg_r <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wb_we   <= 1'b0;
      result  <= '0;
      wb_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          wb_we <= 1'b0;
          if (accept) begin
            op_r    <= op;
            neg_res <= a_neg ^ b_neg;
            a_neg_r <= a_neg;
            count   <= '0;
            busy    <= 1'b1;
            wb_addr <= rd_in;
            if (special) begin
              state  <= ST_DONE;
              result <= special_res;
              done   <= 1'b1;
              wb_we  <= (rd_in != 5'd0);
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          count <= count + 6'd1;
          if (count == 6'(ITER_COUNT - 1)) begin
            state  <= ST_DONE;
            result <= final_res;
            done   <= 1'b1;
            wb_we  <= (wb_addr != 5'd0);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          wb_we <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          wb_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: directed RV32M vectors, latency and write-back checks.
module tb_rv32m_muldiv_unit;

  localparam int W = 54;  // {exp_cycle[15:0], wb_we, wb_addr[4:0], result[31:0]}

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  wb_addr;
  logic        wb_we;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic         prev_done = 1'b0;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_bad = 0;

  rv32m_muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .wb_addr   (wb_addr),
    .wb_we     (wb_we),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        chk("done_spacing", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got result %h expected no done", result);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", result, mon_e[31:0]);
          chk("wb_addr", {27'd0, wb_addr}, {27'd0, mon_e[36:32]});
          chk("wb_we", {31'd0, wb_we}, {31'd0, mon_e[37]});
          chk("latency", {16'd0, cyc[15:0]}, {16'd0, mon_e[53:38]});
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // driver tasks
  task automatic wait_idle;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout: got busy %b expected 0", busy);
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    op      = o;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
    wait_idle();
    exp_q.push_back({16'(cyc + 1 + lat), (rd != 5'd0), rd, exp});
    drive(o, a, b, rd);
    drain();
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    op      = 3'd0;
    rs1_val = '0;
    rs2_val = '0;
    rd_in   = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_wb_we", {31'd0, wb_we}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // multiplies
    issue(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, MUL_LAT);
    issue(3'b001, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, MUL_LAT);
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, MUL_LAT);
    issue(3'b010, 32'hFFFFFFFF, 32'd2,        5'd3, 32'hFFFFFFFF, MUL_LAT);
    issue(3'b001, 32'hFFFFFFFF, 32'd5,        5'd3, 32'hFFFFFFFF, MUL_LAT);

    // special-case divides
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd4, 32'h80000000, 0);
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'h00000000, 0);
    issue(3'b101, 32'd100,      32'd0,        5'd7, 32'hFFFFFFFF, 0);
    issue(3'b111, 32'd100,      32'd0,        5'd8, 32'd100,      0);
    issue(3'b100, 32'd5,        32'd0,        5'd9, 32'hFFFFFFFF, 0);
    issue(3'b110, 32'hFFFFFFF9, 32'd0,        5'd9, 32'hFFFFFFF9, 0);

    // iterative divides
    issue(3'b110, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 32);
    chk("result_hold", result, 32'hFFFFFFFF);
    issue(3'b100, 32'hFFFFFFF9, 32'd2,        5'd0,  32'hFFFFFFFD, 32);
    issue(3'b100, 32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD, 32);
    issue(3'b110, 32'd7,        32'hFFFFFFFE, 5'd15, 32'd1,        32);
    issue(3'b101, 32'hFFFFFFFF, 32'd1,        5'd16, 32'hFFFFFFFF, 32);
    issue(3'b111, 32'd100,      32'd7,        5'd17, 32'd2,        32);

    // second start while busy must be ignored
    wait_idle();
    exp_q.push_back({16'(cyc + 1 + 32), 1'b1, 5'd10, 32'd14});
    drive(3'b101, 32'd100, 32'd7, 5'd10);
    repeat (4) @(negedge clk);
    drive(3'b000, 32'd9, 32'd9, 5'd11);
    drain();

    // asynchronous reset mid-operation discards the in-flight divide
    wait_idle();
    drive(3'b101, 32'd1000, 32'd3, 5'd12);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("midreset_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(3'b000, 32'd3, 32'd4, 5'd13, 32'd12, MUL_LAT);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
